// File: rtl/shift_register_param.sv
// Parametrised shift/rotate register with a parallel load and an
// automatic multi-cycle logical shift that reports busy and done.
module shift_register_param #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [2:0]       op,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] CNT_MAX = AW'(WIDTH);
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             dir_q, dir_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    amt_sat;

  // Amounts past WIDTH only ever produce all zeros, so clamp them.
  assign amt_sat = (amt > CNT_MAX) ? CNT_MAX : amt;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: manual ops in IDLE, auto-shift in SHIFT.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          cnt_d   = amt_sat;
          state_d = (amt_sat != '0) ? S_SHIFT : S_DONE;
        end else if (ld) begin
          q_d = d;
        end else begin
          unique case (op)
            3'b001: begin
              so_d = q_q[WIDTH-1];
              q_d  = {q_q[WIDTH-2:0], ser_in};
            end
            3'b010: begin
              so_d = q_q[0];
              q_d  = {ser_in, q_q[WIDTH-1:1]};
            end
            3'b011: begin
              so_d = q_q[0];
              q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            end
            3'b100: begin
              so_d = q_q[WIDTH-1];
              q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            end
            3'b101: begin
              so_d = q_q[0];
              q_d  = {q_q[0], q_q[WIDTH-1:1]};
            end
            3'b110: q_d = '0;
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        if (dir_q) begin
          so_d = q_q[0];
          q_d  = {1'b0, q_q[WIDTH-1:1]};
        end else begin
          so_d = q_q[WIDTH-1];
          q_d  = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q       = q_q;
  assign ser_out = so_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_register_param.sv
// Scoreboard bench for shift_register_param at WIDTH=8: a reference
// model pushes expected outputs per cycle, popped after each edge.
module tb_shift_register_param;

  localparam int W  = 8;
  localparam int AW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld = 1'b0;
  logic [2:0]    op = 3'b000;
  logic          ser_in = 1'b0;
  logic [W-1:0]  d = '0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  shift_register_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .op(op), .ser_in(ser_in),
    .d(d), .start(start), .dir(dir), .amt(amt),
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int vecs = 0;
  int errs = 0;
  int n_done = 0;
  int n_busy = 0;

  // model state: 0 idle, 1 shifting, 2 done
  logic [W-1:0] m_q = '0;
  logic         m_so = 1'b0;
  int           m_st = 0;
  int           m_rem = 0;
  logic         m_dir = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    if (!rst) begin
      m_q = '0; m_so = 1'b0; m_st = 0; m_rem = 0; m_dir = 1'b0;
    end else if (m_st == 0) begin
      if (start) begin
        n = int'(amt);
        m_rem = (n > W) ? W : n;
        m_dir = dir;
        m_st  = (m_rem > 0) ? 1 : 2;
      end else if (ld) begin
        m_q = d;
      end else begin
        case (op)
          3'd1: begin m_so = m_q[W-1]; m_q = (m_q << 1) | W'(ser_in); end
          3'd2: begin m_so = m_q[0]; m_q = (m_q >> 1) | {ser_in, 7'b0}; end
          3'd3: begin m_so = m_q[0]; m_q = $signed(m_q) >>> 1; end
          3'd4: begin m_so = m_q[W-1]; m_q = (m_q << 1) | (m_q >> (W-1)); end
          3'd5: begin m_so = m_q[0]; m_q = (m_q >> 1) | (m_q << (W-1)); end
          3'd6: m_q = '0;
          default: ;
        endcase
      end
    end else if (m_st == 1) begin
      if (m_dir) begin m_so = m_q[0]; m_q = m_q >> 1; end
      else begin m_so = m_q[W-1]; m_q = m_q << 1; end
      m_rem--;
      if (m_rem == 0) m_st = 2;
    end else begin
      m_st = 0;
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.q = m_q; e.so = m_so;
    e.busy = (m_st != 0); e.done = (m_st == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("ser_out", 32'(ser_out), 32'(e.so));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
    end
    if (done) n_done++;
    if (busy) n_busy++;
  endtask

  task automatic idle_in();
    ld = 1'b0; op = 3'b000; start = 1'b0; ser_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(q), 32'h0);
    rst = 1'b1;

    // reset in the middle of a sequence
    ld = 1'b1; d = 8'hA5; tick(); idle_in();
    start = 1'b1; dir = 1'b0; amt = 4'd5; tick(); idle_in();
    n_done = 0;
    tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst_mid_q", 32'(q), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    tick(); tick(); tick(); tick(); tick();
    chk("rst_no_done", 32'(n_done), 32'd0);

    // manual ops
    ld = 1'b1; d = 8'hAA; tick(); idle_in();
    op = 3'b001; ser_in = 1'b1; tick(); idle_in();
    chk("shl_q", 32'(q), 32'h55);
    chk("shl_so", 32'(ser_out), 32'h1);
    ld = 1'b1; d = 8'h80; tick(); idle_in();
    op = 3'b011; tick(); idle_in();
    chk("asr_q", 32'(q), 32'hC0);
    chk("asr_so", 32'(ser_out), 32'h0);
    ld = 1'b1; d = 8'h81; tick(); idle_in();
    op = 3'b100; tick(); idle_in();
    chk("rotl_q", 32'(q), 32'h03);
    op = 3'b101; tick();
    op = 3'b010; ser_in = 1'b1; tick();
    op = 3'b111; tick();
    op = 3'b110; tick(); idle_in();
    chk("clr_q", 32'(q), 32'h0);

    // auto right shift by 3
    ld = 1'b1; d = 8'hB4; tick(); idle_in();
    n_done = 0; n_busy = 0;
    start = 1'b1; dir = 1'b1; amt = 4'd3; tick(); idle_in();
    tick(); chk("ar_q1", 32'(q), 32'h5A);
    tick(); chk("ar_q2", 32'(q), 32'h2D);
    tick(); chk("ar_q3", 32'(q), 32'h16);
    tick();
    chk("ar_busy_cycles", 32'(n_busy), 32'd4);
    chk("ar_done_pulses", 32'(n_done), 32'd1);
    chk("ar_so", 32'(ser_out), 32'h1);

    // amt = 0: done right after start, q untouched
    start = 1'b1; amt = 4'd0; tick(); idle_in();
    chk("amt0_done", 32'(done), 32'h1);
    chk("amt0_q", 32'(q), 32'h16);
    tick();

    // amt = 9 saturates to 8
    ld = 1'b1; d = 8'hFF; tick(); idle_in();
    start = 1'b1; dir = 1'b0; amt = 4'd9; tick(); idle_in();
    for (int i = 0; i < 9; i++) tick();
    chk("sat_q", 32'(q), 32'h0);
    tick();

    // start beats ld; inputs ignored while busy
    ld = 1'b1; d = 8'h3C; tick(); idle_in();
    ld = 1'b1; d = 8'h77; start = 1'b1; dir = 1'b1; amt = 4'd2; tick();
    ld = 1'b1; d = 8'h11; start = 1'b1; op = 3'b110; tick();
    tick(); tick(); idle_in();
    chk("busy_ign_q", 32'(q), 32'h0F);
    tick();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 40) != 0);
      ld     = $urandom_range(0, 3) == 0;
      start  = $urandom_range(0, 5) == 0;
      op     = 3'($urandom_range(0, 7));
      ser_in = 1'($urandom);
      d      = 8'($urandom);
      dir    = 1'($urandom);
      amt    = AW'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1; idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
